b_mux4_sync: RTL and testbench
==============================

Name: b_mux4_sync

Overview:
- Synchronous 4-to-1 multiplexer.
- Selects one of four equal-width input lanes packed into a single bus, using a 2-bit select.
- Presents the selected lane two ways: combinationally on y_comb, and registered on y, qualified by y_valid.
- Used as a small datapath selector wherever a mux result must be timing-clean (registered) but a same-cycle peek is also useful.

Parameters:
- WIDTH, 1, bit width of each of the four input lanes and of the outputs.

Ports:
- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  synchronous, active-high reset.
- i  input  4*WIDTH  packed data lanes: lane 0 = i[WIDTH-1:0], lane 1 = i[2*WIDTH-1:WIDTH], lane 2 = i[3*WIDTH-1:2*WIDTH], lane 3 = i[4*WIDTH-1:3*WIDTH].
- s  input  2  lane select, 0..3.
- en  input  1  capture enable for the output register.
- y_comb  output  WIDTH  combinational selected lane.
- y  output  WIDTH  registered selected lane.
- y_valid  output  1  high once y holds a captured value since the last reset.

Interface (already decided):
- One clock (clk).
- Reset rst is synchronous and active-high.

Behaviour:
- Combinational path:
  - y_comb = lane[s] at all times, independent of clk, rst and en.
  - s=0 -> lane 0, s=1 -> lane 1, s=2 -> lane 2, s=3 -> lane 3.
  - All four select codes are legal; there is no error or default case.
- Register update, evaluated on every rising clk edge in priority order:
  - If rst=1: y <= 0 (all WIDTH bits) and y_valid <= 0. rst overrides en.
  - Else if en=1: y <= lane[s] as sampled at that edge, and y_valid <= 1.
  - Else: y and y_valid hold their values.
- Latency: y equals y_comb sampled at the capturing edge, so the registered path has a 1-cycle latency.
- Changes on i or s between edges have no effect on y.
- Reset behaviour:
  - Reset value of every register: y=0, y_valid=0.
  - Asserting rst mid-stream clears y at the next edge, even if en=1 on that same edge.
  - Deasserting rst: the first edge with rst=0 and en=1 captures data and raises y_valid.
- y_valid, once set, stays 1 until the next reset; deasserting en does not clear it.
- Width rules: no arithmetic; lane slices are exact WIDTH-bit copies with no extension or truncation.
- Before the first clk edge, y and y_valid are undefined; the bench must apply rst for at least one edge.
- No X-propagation handling is required beyond normal simulation semantics.

Test Plan:
- Reset: rst=1 for 2 edges with en=1, i=4'hF, s=3 (WIDTH=1) -> y=0 and y_valid=0 after each edge; y_comb=1 throughout.
- Combinational sweep, WIDTH=1: hold rst=0, en=0; step i through 0..15 and s through 0..3 together (mirroring the counting stimulus) -> y_comb = i[s] for every step, e.g. i=4'b1010, s=1 -> y_comb=1; i=4'b1010, s=2 -> y_comb=0. y holds its prior value throughout.
- Registered capture: en=1, i=4'b0100, s=2 -> after 1 edge y=1, y_valid=1. Then i=4'b0100, s=3 -> after the next edge y=0.
- Hold: after a capture of y=1, set en=0 and change i=0, s=0 for 3 edges -> y stays 1, y_valid stays 1, y_comb=0.
- Mid-operation reset: en=1 with captures in progress; assert rst for 1 edge -> y=0, y_valid=0. Deassert rst with en=1, i=4'b1000, s=3 -> next edge y=1, y_valid=1.
- Wide lanes, WIDTH=8: i=32'hDDCCBBAA; s=0,1,2,3 with en=1 -> y = 8'hAA, 8'hBB, 8'hCC, 8'hDD on successive edges, each appearing one cycle after its s value.

Source files
------------

// File: rtl/b_mux4_sync.sv
// Synchronous 4-to-1 lane multiplexer: the selected lane is shown combinationally
// on y_comb and captured into y (qualified by y_valid) on enabled clock edges.
module b_mux4_sync #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*WIDTH-1:0] i,
  input  logic [1:0]         s,
  input  logic               en,
  output logic [WIDTH-1:0]   y_comb,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid
);

  // Qualifier: y_valid rises on the first enabled capture after reset and
  // stays high until the next reset; en low only freezes y, it never clears y_valid.

  always_comb begin
    y_comb = i[WIDTH-1:0];
    case (s)
      2'd0: y_comb = i[WIDTH-1:0];
      2'd1: y_comb = i[2*WIDTH-1:WIDTH];
      2'd2: y_comb = i[3*WIDTH-1:2*WIDTH];
      2'd3: y_comb = i[4*WIDTH-1:3*WIDTH];
      default: y_comb = i[WIDTH-1:0];
    endcase
  end

  // Reset has priority over en so a mid-stream reset always clears the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else if (en) begin
      y       <= y_comb;
      y_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_b_mux4_sync.sv
// Self-checking bench for b_mux4_sync: a WIDTH=1 and a WIDTH=8 instance are
// driven with directed and random stimulus against a lane-shift reference model.
module tb_b_mux4_sync;

  logic clk;
  logic rst1, en1;
  logic [3:0] i1;
  logic [1:0] s1;
  logic       y_comb1, y1, y_valid1;

  logic rst8, en8;
  logic [31:0] i8;
  logic [1:0]  s8;
  logic [7:0]  y_comb8, y8;
  logic        y_valid8;

  int n_checks = 0;
  int n_pass   = 0;

  // reference state for the WIDTH=1 instance
  logic m_y1;
  logic m_v1;

  logic [7:0] exp_q[$];

  b_mux4_sync #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .i(i1), .s(s1), .en(en1),
    .y_comb(y_comb1), .y(y1), .y_valid(y_valid1)
  );

  b_mux4_sync #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .i(i8), .s(s8), .en(en8),
    .y_comb(y_comb8), .y(y8), .y_valid(y_valid8)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst1 = 1'b1; en1 = 1'b0; i1 = '0; s1 = '0;
    rst8 = 1'b1; en8 = 1'b0; i8 = '0; s8 = '0;
    m_y1 = 1'b0; m_v1 = 1'b0;
  end

  // lane selection from the spec's rule: lane k occupies bits [k*w +: w]
  function automatic logic [31:0] lane_of(input logic [31:0] bus, input int sel, input int w);
    logic [31:0] mask;
    mask = (32'h1 << w) - 32'h1;
    return (bus >> (sel * w)) & mask;
  endfunction

  // one clock edge; the model sees the same inputs the DUT samples
  task automatic tick();
    @(posedge clk);
    if (rst1) begin
      m_y1 = 1'b0;
      m_v1 = 1'b0;
    end else if (en1) begin
      m_y1 = lane_of({28'h0, i1}, int'(s1), 1) != 0;
      m_v1 = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; en1 = 1'b1; i1 = 4'hF; s1 = 2'd3;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (y1 !== 1'b0) $display("FAIL reset_y edge%0d: got %b want 0", k, y1); else n_pass++;
      n_checks++;
      if (y_valid1 !== 1'b0) $display("FAIL reset_valid edge%0d: got %b want 0", k, y_valid1); else n_pass++;
      n_checks++;
      if (y_comb1 !== 1'b1) $display("FAIL reset_ycomb edge%0d: got %b want 1", k, y_comb1); else n_pass++;
    end
  endtask

  task automatic test_comb_sweep();
    logic want;
    rst1 = 1'b0; en1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      i1 = 4'(k); s1 = 2'(k % 4);
      #1;
      want = lane_of({28'h0, i1}, k % 4, 1) != 0;
      n_checks++;
      if (y_comb1 !== want) $display("FAIL comb_sweep i=%h s=%0d: got %b want %b", i1, s1, y_comb1, want); else n_pass++;
      tick();
      n_checks++;
      if (y1 !== m_y1 || y_valid1 !== m_v1)
        $display("FAIL comb_sweep_hold step%0d: got y=%b v=%b want y=%b v=%b", k, y1, y_valid1, m_y1, m_v1);
      else n_pass++;
    end
    i1 = 4'b1010; s1 = 2'd1; #1;
    n_checks++;
    if (y_comb1 !== 1'b1) $display("FAIL comb_1010_s1: got %b want 1", y_comb1); else n_pass++;
    s1 = 2'd2; #1;
    n_checks++;
    if (y_comb1 !== 1'b0) $display("FAIL comb_1010_s2: got %b want 0", y_comb1); else n_pass++;
  endtask

  task automatic test_capture();
    rst1 = 1'b0; en1 = 1'b1; i1 = 4'b0100; s1 = 2'd2;
    tick();
    n_checks++;
    if (y1 !== 1'b1 || y_valid1 !== 1'b1) $display("FAIL capture_s2: got y=%b v=%b want y=1 v=1", y1, y_valid1); else n_pass++;
    s1 = 2'd3;
    tick();
    n_checks++;
    if (y1 !== 1'b0 || y_valid1 !== 1'b1) $display("FAIL capture_s3: got y=%b v=%b want y=0 v=1", y1, y_valid1); else n_pass++;
  endtask

  task automatic test_hold();
    rst1 = 1'b0; en1 = 1'b1; i1 = 4'b0100; s1 = 2'd2;
    tick();
    en1 = 1'b0; i1 = 4'h0; s1 = 2'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (y1 !== 1'b1 || y_valid1 !== 1'b1 || y_comb1 !== 1'b0)
        $display("FAIL hold edge%0d: got y=%b v=%b yc=%b want y=1 v=1 yc=0", k, y1, y_valid1, y_comb1);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    rst1 = 1'b0; en1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i1 = 4'($urandom_range(0, 15)); s1 = 2'($urandom_range(0, 3));
      tick();
      n_checks++;
      if (y1 !== m_y1 || y_valid1 !== m_v1)
        $display("FAIL mid_stream cap%0d: got y=%b v=%b want y=%b v=%b", k, y1, y_valid1, m_y1, m_v1);
      else n_pass++;
    end
    rst1 = 1'b1; en1 = 1'b1; i1 = 4'hF; s1 = 2'd0;
    tick();
    n_checks++;
    if (y1 !== 1'b0 || y_valid1 !== 1'b0) $display("FAIL mid_reset: got y=%b v=%b want y=0 v=0", y1, y_valid1); else n_pass++;
    rst1 = 1'b0; en1 = 1'b1; i1 = 4'b1000; s1 = 2'd3;
    tick();
    n_checks++;
    if (y1 !== 1'b1 || y_valid1 !== 1'b1) $display("FAIL post_reset_capture: got y=%b v=%b want y=1 v=1", y1, y_valid1); else n_pass++;
  endtask

  task automatic test_random();
    logic want_c;
    for (int k = 0; k < 60; k++) begin
      rst1 = ($urandom_range(0, 9) == 0);
      en1  = 1'($urandom_range(0, 1));
      i1   = 4'($urandom_range(0, 15));
      s1   = 2'($urandom_range(0, 3));
      #1;
      want_c = lane_of({28'h0, i1}, int'(s1), 1) != 0;
      n_checks++;
      if (y_comb1 !== want_c) $display("FAIL random_comb step%0d: got %b want %b", k, y_comb1, want_c); else n_pass++;
      tick();
      n_checks++;
      if (y1 !== m_y1 || y_valid1 !== m_v1)
        $display("FAIL random_reg step%0d: got y=%b v=%b want y=%b v=%b", k, y1, y_valid1, m_y1, m_v1);
      else n_pass++;
    end
    rst1 = 1'b0; en1 = 1'b0;
  endtask

  task automatic test_wide();
    logic [7:0] want;
    logic [7:0] fixed[4];
    fixed[0] = 8'hAA; fixed[1] = 8'hBB; fixed[2] = 8'hCC; fixed[3] = 8'hDD;
    rst8 = 1'b1; en8 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (y8 !== 8'h00 || y_valid8 !== 1'b0) $display("FAIL wide_reset: got y=%h v=%b want y=00 v=0", y8, y_valid8); else n_pass++;
    rst8 = 1'b0; i8 = 32'hDDCCBBAA;
    for (int k = 0; k < 4; k++) begin
      s8 = 2'(k);
      #1;
      exp_q.push_back(8'(lane_of(i8, k, 8)));
      n_checks++;
      if (y_comb8 !== fixed[k]) $display("FAIL wide_comb s=%0d: got %h want %h", k, y_comb8, fixed[k]); else n_pass++;
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (y8 !== want || y8 !== fixed[k] || y_valid8 !== 1'b1)
        $display("FAIL wide_capture s=%0d: got y=%h v=%b want y=%h v=1", k, y8, y_valid8, fixed[k]);
      else n_pass++;
    end
    for (int k = 0; k < 20; k++) begin
      i8 = $urandom(); s8 = 2'($urandom_range(0, 3)); en8 = 1'($urandom_range(0, 1));
      #1;
      if (en8) exp_q.push_back(8'(lane_of(i8, int'(s8), 8)));
      else     exp_q.push_back(y8);
      @(posedge clk); #1;
      want = exp_q.pop_front();
      n_checks++;
      if (y8 !== want || y_valid8 !== 1'b1) $display("FAIL wide_random step%0d: got y=%h v=%b want y=%h v=1", k, y8, y_valid8, want); else n_pass++;
    end
    en8 = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_comb_sweep();
    test_capture();
    test_hold();
    test_mid_reset();
    test_random();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
